// File: rtl/rstack_spill_unit_pkg.sv
// Shared encodings for the return-address stack with memory spill/fill.
package rstack_spill_unit_pkg;

   localparam logic [1:0] RS_NOP  = 2'b00;
   localparam logic [1:0] RS_PUSH = 2'b01;
   localparam logic [1:0] RS_POP  = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SPILL = 2'd1;
   localparam logic [1:0] ST_FILL  = 2'd2;

   localparam logic [15:0] RS_SPILL_BASE_DFLT = 16'hFE00;

endpackage

// File: rtl/rstack_spill_unit_if.sv
// PC-path request/response and spill memory bus of the return stack.
interface rstack_spill_unit_if #(
   parameter int unsigned WIDTH = 16
);
   logic [1:0]       stackOP;
   logic [WIDTH-1:0] w;
   logic [WIDTH-1:0] a;
   logic             Busy;
   logic             Overflow;
   logic             Underflow;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport slave (
      input  stackOP, w, mem_rdata, mem_ack,
      output a, Busy, Overflow, Underflow, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output stackOP, w, mem_rdata, mem_ack,
      input  a, Busy, Overflow, Underflow, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rstack_spill_unit_lifo.sv
// On-chip LIFO: entry[0] is the oldest, top is entry[count-1].
module rstack_lifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] shift_data_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] top_o,
   output logic [WIDTH-1:0] bottom_o
);

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [CW-1:0]    count_q;

   // Entry array and occupancy; the control never raises two ops at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else if (shift_i) begin
         for (int i = 0; i < DEPTH - 1; i++) entry_q[i] <= entry_q[i+1];
         entry_q[DEPTH-1] <= shift_data_i;
      end else if (load_i) begin
         entry_q[0] <= load_data_i;
         count_q    <= CW'(1);
      end else if (push_i) begin
         for (int i = 0; i < DEPTH; i++)
            if (count_q == CW'(i)) entry_q[i] <= push_data_i;
         count_q <= count_q + CW'(1);
      end else if (pop_i) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Top-of-stack select; zero when empty.
   always_comb begin
      top_o = '0;
      for (int i = 0; i < DEPTH; i++)
         if (count_q == CW'(i + 1)) top_o = entry_q[i];
   end

   assign count_o  = count_q;
   assign bottom_o = entry_q[0];

endmodule

// File: rtl/rstack_spill_unit.sv
// Return-address stack with automatic spill/fill of the oldest entry to memory.
module rstack_spill_unit
   import rstack_spill_unit_pkg::*;
#(
   parameter int unsigned      WIDTH      = 16,
   parameter int unsigned      DEPTH      = 8,
   parameter logic [WIDTH-1:0] SPILL_BASE = WIDTH'(RS_SPILL_BASE_DFLT),
   parameter int unsigned      MAX_SPILL  = 64
) (
   input  logic                CLK,
   input  logic                Reset,
   rstack_spill_unit_if.slave  rs
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(MAX_SPILL + 1);

   // Spill area must not wrap the address space; the stack needs two entries.
   if (DEPTH < 2 ||
       (64'(SPILL_BASE) + 64'(2 * MAX_SPILL)) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_cfg
      $error("rstack_spill_unit: invalid DEPTH or spill area wraps");
   end

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    spill_cnt_q, spill_cnt_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic             push_c, pop_c, shift_c, load_c;
   logic [CW-1:0]    count_c;
   logic [WIDTH-1:0] top_c, bottom_c;

   function automatic logic [WIDTH-1:0] slot_addr(input logic [SW-1:0] k);
      return SPILL_BASE + WIDTH'({k, 1'b0});
   endfunction

   rstack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
      .clk          (CLK),
      .rst_n        (Reset),
      .push_i       (push_c),
      .push_data_i  (rs.w),
      .pop_i        (pop_c),
      .shift_i      (shift_c),
      .shift_data_i (pend_q),
      .load_i       (load_c),
      .load_data_i  (rs.mem_rdata),
      .count_o      (count_c),
      .top_o        (top_c),
      .bottom_o     (bottom_c)
   );

   // Control state and registered outputs.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         spill_cnt_q <= '0;
         pend_q      <= '0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         spill_cnt_q <= spill_cnt_d;
         pend_q      <= pend_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Op decode in IDLE, handshake completion in SPILL/FILL.
   always_comb begin
      state_d     = state_q;
      spill_cnt_d = spill_cnt_q;
      pend_d      = pend_q;
      busy_d      = busy_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      shift_c     = 1'b0;
      load_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rs.stackOP == RS_PUSH) begin
               if (count_c < CW'(DEPTH)) begin
                  push_c = 1'b1;
               end else if (spill_cnt_q < SW'(MAX_SPILL)) begin
                  pend_d      = rs.w;
                  state_d     = ST_SPILL;
                  busy_d      = 1'b1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = slot_addr(spill_cnt_q);
                  mem_wdata_d = bottom_c;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (rs.stackOP == RS_POP) begin
               if (count_c != '0) begin
                  pop_c = 1'b1;
                  // Eager refill keeps a valid for the next return.
                  if (count_c == CW'(1) && spill_cnt_q != '0) begin
                     state_d     = ST_FILL;
                     busy_d      = 1'b1;
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b0;
                     mem_addr_d  = slot_addr(spill_cnt_q - SW'(1));
                     mem_wdata_d = '0;
                  end
               end else begin
                  unf_d = 1'b1;
               end
            end
         end
         ST_SPILL: begin
            if (rs.mem_ack) begin
               shift_c     = 1'b1;
               spill_cnt_d = spill_cnt_q + SW'(1);
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
            end
         end
         ST_FILL: begin
            if (rs.mem_ack) begin
               load_c      = 1'b1;
               spill_cnt_d = spill_cnt_q - SW'(1);
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               mem_req_d   = 1'b0;
               mem_addr_d  = '0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
         end
      endcase
   end

   assign rs.a         = top_c;
   assign rs.Busy      = busy_q;
   assign rs.Overflow  = ovf_q;
   assign rs.Underflow = unf_q;
   assign rs.mem_req   = mem_req_q;
   assign rs.mem_we    = mem_we_q;
   assign rs.mem_addr  = mem_addr_q;
   assign rs.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rstack_spill_unit.sv
// Bench for rstack_spill_unit: DEPTH=4 and DEPTH=2/MAX_SPILL=1 instances,
// a logical-stack model for top-of-stack and a queue of expected memory transactions.
module tb_rstack_spill_unit;
   import rstack_spill_unit_pkg::*;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } mem_txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rstack_spill_unit_if #(.WIDTH(16)) f4 ();
   rstack_spill_unit_if #(.WIDTH(16)) f2 ();

   rstack_spill_unit #(.WIDTH(16), .DEPTH(4), .SPILL_BASE(16'hFE00), .MAX_SPILL(64)) u_d4 (
      .CLK(clk), .Reset(rst_n), .rs(f4.slave));
   rstack_spill_unit #(.WIDTH(16), .DEPTH(2), .SPILL_BASE(16'hFE00), .MAX_SPILL(1)) u_d2 (
      .CLK(clk), .Reset(rst_n), .rs(f2.slave));

   mem_txn_t    exp4[$];
   mem_txn_t    exp2[$];
   logic [15:0] stk4[$];
   logic [15:0] stk2[$];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          ack_en4 = 1'b1;
   int          stray_req4 = 0;
   int          stray_seen4 = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] a_of(input int sel);
      return (sel == 4) ? f4.a : f2.a;
   endfunction
   function automatic logic busy_of(input int sel);
      return (sel == 4) ? f4.Busy : f2.Busy;
   endfunction
   function automatic logic req_of(input int sel);
      return (sel == 4) ? f4.mem_req : f2.mem_req;
   endfunction

   task automatic drive(input int sel, input logic [1:0] op, input logic [15:0] d);
      if (sel == 4) begin f4.stackOP = op; f4.w = d; end
      else          begin f2.stackOP = op; f2.w = d; end
   endtask

   task automatic push(input int sel, input logic [15:0] d, input bit dropped);
      @(negedge clk);
      drive(sel, RS_PUSH, d);
      @(posedge clk); #1;
      drive(sel, RS_NOP, 16'h0);
      if (!dropped) begin
         if (sel == 4) stk4.push_back(d); else stk2.push_back(d);
      end
   endtask

   // a must show the pre-pop top during the pop cycle.
   task automatic pop(input int sel, input string tag);
      logic [15:0] e;
      e = 16'h0;
      @(negedge clk);
      drive(sel, RS_POP, 16'h0);
      #1;
      if (sel == 4) begin if (stk4.size() > 0) e = stk4.pop_back(); end
      else          begin if (stk2.size() > 0) e = stk2.pop_back(); end
      chk(tag, a_of(sel), e);
      @(posedge clk); #1;
      drive(sel, RS_NOP, 16'h0);
   endtask

   task automatic check_top(input int sel, input string tag);
      logic [15:0] e;
      e = 16'h0;
      if (sel == 4) begin if (stk4.size() > 0) e = stk4[$]; end
      else          begin if (stk2.size() > 0) e = stk2[$]; end
      chk(tag, a_of(sel), e);
   endtask

   task automatic wait_idle(input int sel, input string tag);
      int k;
      k = 0;
      while (busy_of(sel) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 16'(busy_of(sel)), 16'd0);
   endtask

   task automatic quiet(input int sel, input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         seen |= req_of(sel);
      end
      chk(tag, 16'(seen), 16'd0);
   endtask

   // Memory model for the DEPTH=4 instance: ack 3 cycles after request.
   initial begin : resp4
      mem_txn_t t;
      f4.mem_ack = 1'b0;
      f4.mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (stray_req4 != stray_seen4) begin
            stray_seen4++;
            f4.mem_rdata = 16'hDEAD;
            f4.mem_ack = 1'b1;
            @(negedge clk);
            f4.mem_ack = 1'b0;
            f4.mem_rdata = 16'h0;
         end else if (rst_n && ack_en4 && f4.mem_req) begin
            if (exp4.size() == 0) begin
               chk("d4 unexpected mem_req", 16'(f4.mem_req), 16'd0);
               t = '{we: f4.mem_we, addr: f4.mem_addr, data: 16'h0};
            end else begin
               t = exp4.pop_front();
               chk("d4 mem_we", 16'(f4.mem_we), 16'(t.we));
               chk("d4 mem_addr", f4.mem_addr, t.addr);
               if (t.we) chk("d4 mem_wdata", f4.mem_wdata, t.data);
            end
            repeat (2) @(negedge clk);
            f4.mem_rdata = t.we ? 16'h0 : t.data;
            f4.mem_ack = 1'b1;
            @(negedge clk);
            f4.mem_ack = 1'b0;
            f4.mem_rdata = 16'h0;
         end
      end
   end

   // Memory model for the DEPTH=2 instance.
   initial begin : resp2
      mem_txn_t t;
      f2.mem_ack = 1'b0;
      f2.mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (rst_n && f2.mem_req) begin
            if (exp2.size() == 0) begin
               chk("d2 unexpected mem_req", 16'(f2.mem_req), 16'd0);
               t = '{we: f2.mem_we, addr: f2.mem_addr, data: 16'h0};
            end else begin
               t = exp2.pop_front();
               chk("d2 mem_we", 16'(f2.mem_we), 16'(t.we));
               chk("d2 mem_addr", f2.mem_addr, t.addr);
               if (t.we) chk("d2 mem_wdata", f2.mem_wdata, t.data);
            end
            repeat (2) @(negedge clk);
            f2.mem_rdata = t.we ? 16'h0 : t.data;
            f2.mem_ack = 1'b1;
            @(negedge clk);
            f2.mem_ack = 1'b0;
            f2.mem_rdata = 16'h0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      drive(4, RS_NOP, 16'h0);
      drive(2, RS_NOP, 16'h0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst a", f4.a, 16'h0);
      chk("rst Busy", 16'(f4.Busy), 16'd0);
      chk("rst Overflow", 16'(f4.Overflow), 16'd0);
      chk("rst Underflow", 16'(f4.Underflow), 16'd0);
      chk("rst mem_req", 16'(f4.mem_req), 16'd0);
      chk("rst mem_we", 16'(f4.mem_we), 16'd0);
      chk("rst mem_addr", f4.mem_addr, 16'h0);
      chk("rst mem_wdata", f4.mem_wdata, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Simple push/pop without stalls
      push(4, 16'h0002, 1'b0);
      push(4, 16'h0004, 1'b0);
      check_top(4, "t1 top after pushes");
      chk("t1 Busy", 16'(f4.Busy), 16'd0);
      pop(4, "t1 pop1");
      pop(4, "t1 pop2");
      check_top(4, "t1 empty a");
      chk("t1 Busy end", 16'(f4.Busy), 16'd0);

      // Pop on empty, reserved op
      pop(4, "t5 pop empty a");
      chk("t5 Underflow", 16'(f4.Underflow), 16'd1);
      quiet(4, "t5 no mem_req", 4);
      @(negedge clk);
      drive(4, 2'b11, 16'h00AA);
      @(posedge clk); #1;
      drive(4, RS_NOP, 16'h0);
      check_top(4, "t5 rsvd a");
      chk("t5 rsvd Busy", 16'(f4.Busy), 16'd0);

      // Fill on-chip stack, then spill
      push(4, 16'h0010, 1'b0);
      push(4, 16'h0020, 1'b0);
      push(4, 16'h0030, 1'b0);
      push(4, 16'h0040, 1'b0);
      @(negedge clk);
      drive(4, 2'b11, 16'h00AA);
      @(posedge clk); #1;
      drive(4, RS_NOP, 16'h0);
      check_top(4, "t2 rsvd when full");
      exp4.push_back('{we: 1'b1, addr: 16'hFE00, data: 16'h0010});
      push(4, 16'h0050, 1'b0);
      chk("t2 Busy asserted", 16'(f4.Busy), 16'd1);
      chk("t2 mem_req asserted", 16'(f4.mem_req), 16'd1);
      wait_idle(4, "t2 spill done");
      check_top(4, "t2 top after spill");

      // Drain and refill
      pop(4, "t3 pop 50");
      pop(4, "t3 pop 40");
      pop(4, "t3 pop 30");
      exp4.push_back('{we: 1'b0, addr: 16'hFE00, data: 16'h0010});
      pop(4, "t3 pop 20");
      chk("t3 fill Busy", 16'(f4.Busy), 16'd1);
      wait_idle(4, "t3 fill done");
      check_top(4, "t3 top after fill");
      pop(4, "t3 pop 10");
      quiet(4, "t3 no further req", 5);
      check_top(4, "t3 empty");

      // Two spills to consecutive slots, two fills in reverse order
      for (int i = 1; i <= 4; i++) push(4, 16'(i * 256), 1'b0);
      exp4.push_back('{we: 1'b1, addr: 16'hFE00, data: 16'h0100});
      push(4, 16'h0500, 1'b0);
      wait_idle(4, "t3b spill0");
      exp4.push_back('{we: 1'b1, addr: 16'hFE02, data: 16'h0200});
      push(4, 16'h0600, 1'b0);
      wait_idle(4, "t3b spill1");
      check_top(4, "t3b top");
      pop(4, "t3b pop 600");
      pop(4, "t3b pop 500");
      pop(4, "t3b pop 400");
      exp4.push_back('{we: 1'b0, addr: 16'hFE02, data: 16'h0200});
      pop(4, "t3b pop 300");
      wait_idle(4, "t3b fill1");
      check_top(4, "t3b top after fill1");
      exp4.push_back('{we: 1'b0, addr: 16'hFE00, data: 16'h0100});
      pop(4, "t3b pop 200");
      wait_idle(4, "t3b fill0");
      check_top(4, "t3b top after fill0");
      pop(4, "t3b pop 100");
      quiet(4, "t3b no further req", 4);
      chk("t3b exp queue drained", 16'(exp4.size()), 16'd0);

      // Reset in the middle of a spill
      for (int i = 0; i < 4; i++) push(4, 16'(16'hA1 + i), 1'b0);
      ack_en4 = 1'b0;
      push(4, 16'h00A5, 1'b1);
      @(negedge clk);
      chk("t6 mem_req before reset", 16'(f4.mem_req), 16'd1);
      chk("t6 mem_addr before reset", f4.mem_addr, 16'hFE00);
      chk("t6 mem_wdata before reset", f4.mem_wdata, 16'h00A1);
      rst_n = 1'b0;
      #1;
      chk("t6 mem_req async drop", 16'(f4.mem_req), 16'd0);
      chk("t6 Busy async drop", 16'(f4.Busy), 16'd0);
      chk("t6 Underflow cleared", 16'(f4.Underflow), 16'd0);
      chk("t6 a cleared", f4.a, 16'h0);
      stk4.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ack_en4 = 1'b1;
      stray_req4++;
      repeat (3) @(negedge clk);
      chk("t6 stray ack mem_req", 16'(f4.mem_req), 16'd0);
      chk("t6 stray ack Busy", 16'(f4.Busy), 16'd0);
      check_top(4, "t6 stray ack a");
      push(4, 16'h1234, 1'b0);
      check_top(4, "t6 push after reset");
      pop(4, "t6 pop after reset");
      quiet(4, "t6 no fill after reset", 4);

      // Overflow on the small instance
      push(2, 16'h0001, 1'b0);
      push(2, 16'h0002, 1'b0);
      exp2.push_back('{we: 1'b1, addr: 16'hFE00, data: 16'h0001});
      push(2, 16'h0003, 1'b0);
      chk("t4 spill Busy", 16'(f2.Busy), 16'd1);
      wait_idle(2, "t4 spill done");
      check_top(2, "t4 top after spill");
      chk("t4 Overflow before", 16'(f2.Overflow), 16'd0);
      push(2, 16'h0004, 1'b1);
      chk("t4 Overflow", 16'(f2.Overflow), 16'd1);
      chk("t4 Busy after drop", 16'(f2.Busy), 16'd0);
      check_top(2, "t4 top unchanged");
      quiet(2, "t4 no mem_req on drop", 4);
      pop(2, "t4 pop 3");
      exp2.push_back('{we: 1'b0, addr: 16'hFE00, data: 16'h0001});
      pop(2, "t4 pop 2");
      wait_idle(2, "t4 fill done");
      check_top(2, "t4 top after fill");
      pop(2, "t4 pop 1");
      chk("t4 Overflow sticky", 16'(f2.Overflow), 16'd1);
      chk("t4 exp queue drained", 16'(exp2.size()), 16'd0);
      chk("end exp4 drained", 16'(exp4.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
